// File: rtl/mem_region_controller.sv
// mem_region_controller: burst command front end that steers each burst to
// an embedded RAM or to an external req/ack memory port.
//
// state         | meaning
// S_IDLE        | waiting for a command, cmd_ready high
// S_INT_WR      | internal write burst, one beat per wr handshake
// S_INT_RD      | internal read burst, one RAM read issued per cycle
// S_INT_RD_LAST | last internal read beat returning
// S_EXT_WR      | external write burst, one req/ack per beat
// S_EXT_RD      | external read burst, one req/ack per beat
// S_FIN         | done pulse (with err if the burst failed)
module mem_region_controller #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 20,
    parameter int INT_ADDR_WIDTH = 8,
    parameter int LEN_WIDTH      = 4,
    parameter int EXT_TIMEOUT    = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_we,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [LEN_WIDTH-1:0]  i_cmd_len,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_ext_req,
    output logic                  o_ext_we,
    output logic [ADDR_WIDTH-1:0] o_ext_addr,
    output logic [DATA_WIDTH-1:0] o_ext_wdata,
    input  logic [DATA_WIDTH-1:0] i_ext_rdata,
    input  logic                  i_ext_ack
);

    localparam int TMO_WIDTH = $clog2(EXT_TIMEOUT + 1);
    localparam logic [TMO_WIDTH-1:0]  TMO_LOAD = TMO_WIDTH'(EXT_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH:0]   INT_SIZE = {{ADDR_WIDTH{1'b0}}, 1'b1} << INT_ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   ADDR_MAX = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_INT_WR,
        S_INT_RD,
        S_INT_RD_LAST,
        S_EXT_WR,
        S_EXT_RD,
        S_FIN
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [LEN_WIDTH-1:0]      r_cnt;
    logic                      r_err;
    logic [TMO_WIDTH-1:0]      r_tmo;
    logic                      r_ext_req;
    logic                      r_ext_we;
    logic [ADDR_WIDTH-1:0]     r_ext_addr;
    logic [DATA_WIDTH-1:0]     r_ext_wdata;
    logic [DATA_WIDTH-1:0]     r_rd_data;
    logic                      r_rd_valid;
    logic [DATA_WIDTH-1:0]     mem [0:(2**INT_ADDR_WIDTH)-1];

    logic [ADDR_WIDTH:0]       w_start;
    logic [ADDR_WIDTH:0]       w_end;
    logic                      w_start_int;
    logic                      w_cmd_err;
    logic                      w_last;
    logic                      w_wr_fire;
    logic                      w_ext_ack;
    logic                      w_ext_tmo;
    logic [INT_ADDR_WIDTH-1:0] w_mem_idx;

    // A burst that would wrap the address space or straddle the internal/external
    // boundary is rejected as a whole before any beat is issued.
    assign w_start     = {1'b0, i_cmd_addr};
    assign w_end       = w_start + {{(ADDR_WIDTH + 1 - LEN_WIDTH){1'b0}}, i_cmd_len};
    assign w_start_int = (w_start < INT_SIZE);
    assign w_cmd_err   = (w_end > ADDR_MAX) || (w_start_int && (w_end >= INT_SIZE));

    assign w_last      = (r_cnt == '0);
    assign w_wr_fire   = i_wr_valid && o_wr_ready;
    assign w_ext_ack   = r_ext_req && i_ext_ack;
    assign w_ext_tmo   = r_ext_req && !i_ext_ack && (r_tmo == '0);
    assign w_mem_idx   = r_addr[INT_ADDR_WIDTH-1:0];

    assign o_cmd_ready = (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_FIN);
    assign o_err       = (r_state == S_FIN) && r_err;
    assign o_wr_ready  = (r_state == S_INT_WR) || ((r_state == S_EXT_WR) && !r_ext_req);
    assign o_ext_req   = r_ext_req;
    assign o_ext_we    = r_ext_we;
    assign o_ext_addr  = r_ext_addr;
    assign o_ext_wdata = r_ext_wdata;
    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    if (w_cmd_err) begin
                        w_state_nxt = S_FIN;
                    end else if (w_start_int) begin
                        w_state_nxt = i_cmd_we ? S_INT_WR : S_INT_RD;
                    end else begin
                        w_state_nxt = i_cmd_we ? S_EXT_WR : S_EXT_RD;
                    end
                end
            end
            S_INT_WR: begin
                if (w_wr_fire && w_last) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_INT_RD: begin
                if (w_last) begin
                    w_state_nxt = S_INT_RD_LAST;
                end
            end
            S_INT_RD_LAST: w_state_nxt = S_FIN;
            S_EXT_WR, S_EXT_RD: begin
                if ((w_ext_ack && w_last) || w_ext_tmo) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Burst bookkeeping, external beat handshake and read-return registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr      <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_tmo       <= '0;
            r_ext_req   <= 1'b0;
            r_ext_we    <= 1'b0;
            r_ext_addr  <= '0;
            r_ext_wdata <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_addr <= i_cmd_addr;
                        r_cnt  <= i_cmd_len;
                        r_err  <= w_cmd_err;
                    end
                end
                S_INT_WR: begin
                    if (i_wr_valid) begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                        r_cnt  <= r_cnt - LEN_WIDTH'(1);
                    end
                end
                S_INT_RD: begin
                    r_rd_data  <= mem[w_mem_idx];
                    r_rd_valid <= 1'b1;
                    r_addr     <= r_addr + ADDR_WIDTH'(1);
                    r_cnt      <= r_cnt - LEN_WIDTH'(1);
                end
                S_EXT_WR, S_EXT_RD: begin
                    if (!r_ext_req) begin
                        // Reads launch on their own; writes wait for a data beat.
                        if ((r_state == S_EXT_RD) || i_wr_valid) begin
                            r_ext_req  <= 1'b1;
                            r_ext_we   <= (r_state == S_EXT_WR);
                            r_ext_addr <= r_addr;
                            r_tmo      <= TMO_LOAD;
                            if (r_state == S_EXT_WR) begin
                                r_ext_wdata <= i_wr_data;
                            end
                        end
                    end else if (i_ext_ack) begin
                        r_ext_req <= 1'b0;
                        r_ext_we  <= 1'b0;
                        r_addr    <= r_addr + ADDR_WIDTH'(1);
                        r_cnt     <= r_cnt - LEN_WIDTH'(1);
                        if (r_state == S_EXT_RD) begin
                            r_rd_data  <= i_ext_rdata;
                            r_rd_valid <= 1'b1;
                        end
                    end else if (r_tmo == '0) begin
                        r_ext_req <= 1'b0;
                        r_ext_we  <= 1'b0;
                        r_err     <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo - TMO_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Internal RAM write port; contents survive reset
    always_ff @(posedge i_clk) begin
        if ((r_state == S_INT_WR) && i_wr_valid) begin
            mem[w_mem_idx] <= i_wr_data;
        end
    end

endmodule

// File: tb/tb_mem_region_controller.sv
// Bench for mem_region_controller: directed command table, hand-written
// timeout and mid-burst reset sequences, then randomized bursts checked
// against a simple memory model and an external memory stub.
module tb_mem_region_controller;

    localparam int DW  = 8;
    localparam int AW  = 20;
    localparam int IAW = 8;
    localparam int LW  = 4;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic          i_cmd_we = 1'b0;
    logic [AW-1:0] i_cmd_addr = '0;
    logic [LW-1:0] i_cmd_len = '0;
    logic [DW-1:0] i_wr_data = '0;
    logic          i_wr_valid = 1'b0;
    logic [DW-1:0] ext_rdata = '0;
    logic          ext_ack = 1'b0;
    logic          o_cmd_ready, o_wr_ready, o_rd_valid, o_busy, o_done, o_err;
    logic          o_ext_req, o_ext_we;
    logic [DW-1:0] o_rd_data, o_ext_wdata;
    logic [AW-1:0] o_ext_addr;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         addr;
        logic [7:0] data;
    } beat_t;

    typedef struct {
        bit          we;
        logic [19:0] addr;
        logic [3:0]  len;
        logic [7:0]  base;
        logic [7:0]  step;
        int          stall_beat;
        bit          noise;
        bit          exp_err;
    } vec_t;

    logic [7:0]  model_int [256];
    logic [7:0]  ext_mem [int];
    beat_t       wlog [$];
    logic [7:0]  wq [$];

    int          ack_delay = 3;
    bit          ack_never = 1'b0;
    bit          spur = 1'b0;
    int          req_cnt = 0;
    int          req_rises = 0;
    int          stable_viol = 0;
    logic        prev_req = 1'b0;
    logic [19:0] held_addr = '0;
    logic [7:0]  held_data = '0;
    logic        held_we = 1'b0;

    mem_region_controller #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INT_ADDR_WIDTH(IAW),
        .LEN_WIDTH(LW), .EXT_TIMEOUT(TMO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_we(i_cmd_we), .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
        .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_ext_req(o_ext_req), .o_ext_we(o_ext_we),
        .o_ext_addr(o_ext_addr), .o_ext_wdata(o_ext_wdata),
        .i_ext_rdata(ext_rdata), .i_ext_ack(ext_ack)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ext_val(input int a);
        if (ext_mem.exists(a)) return ext_mem[a];
        return 8'(a) ^ 8'h5A;
    endfunction

    function automatic bit rule_err(input logic [19:0] addr, input logic [3:0] len);
        int s = int'(addr);
        int e = int'(addr) + int'(len);
        return (e > 20'hFFFFF) || (s < 256 && e >= 256);
    endfunction

    // External memory stub: acks each request after ack_delay cycles
    initial forever begin
        @(negedge clk);
        ext_ack = 1'b0;
        if (!rst_n) begin
            req_cnt  = 0;
            prev_req = 1'b0;
        end else begin
            if (o_ext_req) begin
                if (!prev_req) begin
                    req_rises++;
                    held_addr = o_ext_addr;
                    held_data = o_ext_wdata;
                    held_we   = o_ext_we;
                    req_cnt   = 0;
                end else if (o_ext_addr !== held_addr || o_ext_we !== held_we ||
                             (held_we && o_ext_wdata !== held_data)) begin
                    stable_viol++;
                end
                req_cnt++;
                if (!ack_never && req_cnt >= ack_delay) begin
                    ext_ack   = 1'b1;
                    ext_rdata = ext_val(int'(o_ext_addr));
                    if (o_ext_we) begin
                        ext_mem[int'(o_ext_addr)] = o_ext_wdata;
                        wlog.push_back('{int'(o_ext_addr), o_ext_wdata});
                    end
                end
            end else if (spur && $urandom_range(3) == 0) begin
                ext_ack   = 1'b1;
                ext_rdata = 8'($urandom);
            end
            prev_req = o_ext_req;
        end
    end

    task automatic run_cmd(input bit we, input logic [19:0] addr, input logic [3:0] len,
                           input bit exp_err, input bit exp_tmo, input bit rnd_stall,
                           input int stall_beat, input bit noise);
        int         cyc = 0, beat = 0, done_cyc = 0, req_high = 0;
        int         first_rd = -1, last_rd = -1, busy_bad = 0, stall_left = 10;
        int         rises0, log0, n, base;
        bit         done_seen = 0, err_seen = 0, is_int;
        logic [7:0] rdq [$];
        logic [7:0] exp_d;
        n      = int'(len) + 1;
        base   = int'(addr);
        is_int = base < 256;
        @(negedge clk);
        check("cmd_ready_idle", o_cmd_ready, 1);
        i_cmd_valid = 1'b1;
        i_cmd_we    = we;
        i_cmd_addr  = addr;
        i_cmd_len   = len;
        @(posedge clk);
        rises0 = req_rises;
        log0   = wlog.size();
        while (!done_seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            i_cmd_valid = noise;
            if (noise) begin
                i_cmd_we   = 1'($urandom);
                i_cmd_addr = 20'($urandom);
                i_cmd_len  = 4'($urandom);
            end
            if (!o_busy || o_cmd_ready || (o_err && !o_done)) busy_bad++;
            if (o_ext_req) req_high++;
            if (o_rd_valid) begin
                rdq.push_back(o_rd_data);
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (o_done) begin
                done_seen = 1;
                done_cyc  = cyc;
                err_seen  = o_err;
                i_wr_valid = 1'b0;
            end else if (we && !exp_err && beat < n) begin
                if (stall_beat == beat && stall_left > 0) begin
                    i_wr_valid = 1'b0;
                    stall_left--;
                end else begin
                    i_wr_valid = !(rnd_stall && $urandom_range(2) == 0);
                end
                i_wr_data = wq[beat];
                if (i_wr_valid && o_wr_ready) beat++;
            end else begin
                i_wr_valid = 1'b0;
            end
        end
        i_wr_valid  = 1'b0;
        i_cmd_valid = 1'b0;
        check("done_seen", done_seen, 1);
        if (!done_seen) return;
        check("err_flag", err_seen, exp_err || exp_tmo);
        check("busy_held", busy_bad, 0);
        if (exp_err) begin
            check("err_latency", done_cyc, 1);
            check("err_no_ext", req_rises - rises0, 0);
            check("err_no_rd", rdq.size(), 0);
        end else if (exp_tmo) begin
            check("tmo_req_high", req_high, TMO);
            check("tmo_no_rd", rdq.size(), 0);
        end else if (we) begin
            check("wr_beats", beat, n);
            if (is_int) begin
                for (int i = 0; i < n; i++) begin
                    model_int[base + i] = wq[i];
                    check("int_wr_mem", dut.mem[base + i], wq[i]);
                end
                if (!rnd_stall && stall_beat < 0) check("int_wr_latency", done_cyc, n + 1);
            end else begin
                check("ext_wr_count", wlog.size() - log0, n);
                for (int i = 0; i < n && log0 + i < wlog.size(); i++) begin
                    check("ext_wr_addr", wlog[log0 + i].addr, base + i);
                    check("ext_wr_data", wlog[log0 + i].data, wq[i]);
                end
                check("ext_wr_gaps", req_rises - rises0, n);
            end
        end else begin
            check("rd_count", rdq.size(), n);
            for (int i = 0; i < n && i < rdq.size(); i++) begin
                exp_d = is_int ? model_int[base + i] : ext_val(base + i);
                check("rd_data", rdq[i], exp_d);
            end
            if (is_int) begin
                check("int_rd_first", first_rd, 2);
                check("int_rd_last", last_rd, n + 1);
                check("int_rd_done", done_cyc, n + 2);
            end else begin
                check("ext_rd_gaps", req_rises - rises0, n);
            end
        end
    endtask

    vec_t vecs [13];
    int   dones;
    bit   seen;

    initial begin
        vecs[0]  = '{1'b1, 20'h00010, 4'd3,  8'h55, 8'h01, -1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 20'h00010, 4'd3,  8'h00, 8'h00, -1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 20'h00100, 4'd1,  8'hAA, 8'h11, -1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 20'h00100, 4'd1,  8'h00, 8'h00, -1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 20'h000FE, 4'd3,  8'h99, 8'h01, -1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 20'hFFFFE, 4'd3,  8'h00, 8'h00, -1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 20'h000FC, 4'd3,  8'h10, 8'h03, -1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 20'h000FC, 4'd3,  8'h00, 8'h00, -1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 20'hFFFF0, 4'd15, 8'h00, 8'h00, -1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 20'h00020, 4'd7,  8'h30, 8'h01,  2, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 20'h00020, 4'd7,  8'h00, 8'h00, -1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 20'h000FF, 4'd1,  8'h77, 8'h01, -1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 20'h000FF, 4'd0,  8'h00, 8'h00, -1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", o_cmd_ready, 1);
        check("rst_busy", o_busy, 0);
        check("rst_done_err", {o_done, o_err}, 0);
        check("rst_wr_ready", o_wr_ready, 0);
        check("rst_rd", {o_rd_valid, o_rd_data}, 0);
        check("rst_ext", {o_ext_req, o_ext_we, o_ext_addr, o_ext_wdata}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_rst", {o_cmd_ready, o_busy}, 2'b10);

        // Give the whole internal RAM known contents
        for (int b = 0; b < 16; b++) begin
            wq.delete();
            for (int i = 0; i < 16; i++) wq.push_back(8'($urandom));
            run_cmd(1'b1, 20'(b * 16), 4'd15, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        end

        ack_delay = 3;
        for (int v = 0; v < 13; v++) begin
            wq.delete();
            for (int i = 0; i <= int'(vecs[v].len); i++)
                wq.push_back(8'(vecs[v].base + 8'(i) * vecs[v].step));
            run_cmd(vecs[v].we, vecs[v].addr, vecs[v].len, vecs[v].exp_err, 1'b0,
                    1'b0, vecs[v].stall_beat, vecs[v].noise);
        end

        // Timeout on an external read, then a normal command
        ack_never = 1'b1;
        run_cmd(1'b0, 20'h00200, 4'd2, 1'b0, 1'b1, 1'b0, -1, 1'b0);
        ack_never = 1'b0;
        run_cmd(1'b0, 20'h00010, 4'd3, 1'b0, 1'b0, 1'b0, -1, 1'b0);

        // Reset in the middle of an external write beat
        ack_never = 1'b1;
        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_cmd_we    = 1'b1;
        i_cmd_addr  = 20'h00300;
        i_cmd_len   = 4'd3;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        i_wr_valid  = 1'b1;
        i_wr_data   = 8'h77;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (o_ext_req) seen = 1;
        end
        check("mid_rst_req_seen", seen, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ext_req", o_ext_req, 0);
        check("mid_rst_cmd_ready", o_cmd_ready, 1);
        check("mid_rst_outputs", {o_busy, o_done, o_err, o_wr_ready, o_rd_valid, o_ext_we}, 0);
        @(negedge clk);
        i_wr_valid = 1'b0;
        rst_n      = 1'b1;
        ack_never  = 1'b0;
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_done) dones++;
        end
        check("mid_rst_no_done", dones, 0);
        check("mid_rst_idle", o_cmd_ready, 1);
        for (int i = 0; i < 256; i++) check("mid_rst_mem_kept", dut.mem[i], model_int[i]);

        // Randomized bursts with stalls, varying ack delay and stray acks
        spur = 1'b1;
        for (int t = 0; t < 60; t++) begin
            logic [19:0] a;
            logic [3:0]  l;
            bit          w;
            case ($urandom_range(3))
                0:       a = 20'($urandom_range(255));
                1:       a = 20'(240 + $urandom_range(15));
                2:       a = 20'(256 + $urandom_range(63));
                default: a = 20'(20'hFFFF0 + $urandom_range(15));
            endcase
            l = 4'($urandom);
            w = 1'($urandom);
            ack_delay = 1 + $urandom_range(3);
            wq.delete();
            for (int i = 0; i <= int'(l); i++) wq.push_back(8'($urandom));
            run_cmd(w, a, l, rule_err(a, l), 1'b0, 1'b1, -1, 1'b0);
        end
        spur = 1'b0;

        for (int i = 0; i < 256; i++) check("final_mem", dut.mem[i], model_int[i]);
        check("ext_stable_while_req", stable_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
